// File: rtl/dtw_pkg.sv
// Shared definitions for the DTW datapath: word widths, feature slicing and
// the pair-feeder FSM encoding.
package dtw_pkg;

    localparam int unsigned N      = 32;  // packed feature word
    localparam int unsigned M      = 16;  // distance width
    localparam int unsigned FEAT_W = 8;   // one signed feature
    localparam int unsigned N_FEAT = 4;   // features per word
    localparam int unsigned DEPTH  = 64;
    localparam int unsigned AW     = 6;
    localparam int unsigned LAT    = 1;

    // Bit range of feature k inside a packed word: [feat_msb(k):feat_lsb(k)].
    function automatic int unsigned feat_lsb(input int unsigned k);
        return k * FEAT_W;
    endfunction

    function automatic int unsigned feat_msb(input int unsigned k);
        return k * FEAT_W + FEAT_W - 1;
    endfunction

    // Pair-feeder FSM states.
    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

endpackage

// File: rtl/dtw_tag_delay.sv
// Fixed-depth shift register carrying the {valid,i,j,last} tag of each issued
// pair so it lines up with the distance returned by the distance unit.
module dtw_tag_delay #(
    parameter int unsigned STAGES = 3,
    parameter int unsigned AW     = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [AW-1:0] in_i,
    input  logic [AW-1:0] in_j,
    input  logic          in_last,
    output logic          out_valid,
    output logic [AW-1:0] out_i,
    output logic [AW-1:0] out_j,
    output logic          out_last,
    output logic          any_valid
);

    localparam int unsigned TW = 2 * AW + 2;

    logic [STAGES-1:0][TW-1:0] pipe_q, pipe_d;

    // Advance every tag one stage per clock; stage 0 takes the new tag.
    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = {in_valid, in_i, in_j, in_last};
        for (int s = 1; s < int'(STAGES); s++) begin
            pipe_d[s] = pipe_q[s-1];
        end
    end

    // Tag storage, cleared asynchronously so an aborted run leaves nothing in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    // Any valid bit means a distance is still in flight.
    always_comb begin
        any_valid = 1'b0;
        for (int s = 0; s < int'(STAGES); s++) begin
            any_valid = any_valid | pipe_q[s][TW-1];
        end
    end

    assign {out_valid, out_i, out_j, out_last} = pipe_q[STAGES-1];

endmodule

// File: rtl/dtw_pair_feeder.sv
// Buffers a template and a test sequence, streams every (i,j) pair to the
// distance unit (j outer, i inner) and re-tags the returned distances.
module dtw_pair_feeder
    import dtw_pkg::*;
#(
    parameter int unsigned N     = dtw_pkg::N,
    parameter int unsigned M     = dtw_pkg::M,
    parameter int unsigned DEPTH = dtw_pkg::DEPTH,
    parameter int unsigned AW    = dtw_pkg::AW,
    parameter int unsigned LAT   = dtw_pkg::LAT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic          wr_sel,
    input  logic [AW-1:0] wr_addr,
    input  logic [N-1:0]  wr_data,
    input  logic [AW:0]   tmpl_len,
    input  logic [AW:0]   test_len,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [N-1:0]  template_data,
    output logic [N-1:0]  test_data,
    input  logic [M-1:0]  euclid_in,
    output logic          dist_valid,
    output logic [AW-1:0] dist_i,
    output logic [AW-1:0] dist_j,
    output logic [M-1:0]  dist_data,
    output logic          dist_last
);

    // Clamp a nonzero length to DEPTH and return the last valid index.
    function automatic logic [AW-1:0] last_index(input logic [AW:0] len);
        logic [AW:0] len_m1;
        if (len > (AW+1)'(DEPTH)) begin
            len_m1 = (AW+1)'(DEPTH - 1);
        end else begin
            len_m1 = len - 1'b1;
        end
        return len_m1[AW-1:0];
    endfunction

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] i_q, i_d, j_q, j_d;
    logic [AW-1:0] imax_q, imax_d, jmax_q, jmax_d;
    logic          rd_vld_q, rd_vld_d;
    logic [N-1:0]  tmpl_rd_q, test_rd_q;
    logic [N-1:0]  template_data_q, template_data_d;
    logic [N-1:0]  test_data_q, test_data_d;
    logic          dist_valid_q, dist_valid_d;
    logic [AW-1:0] dist_i_q, dist_i_d, dist_j_q, dist_j_d;
    logic [M-1:0]  dist_data_q, dist_data_d;
    logic          dist_last_q, dist_last_d;

    logic          idle, issue, issue_last, wr_ok;
    logic          tag_valid, tag_last, tag_busy;
    logic [AW-1:0] tag_i, tag_j;

    logic [N-1:0]  tmpl_mem [DEPTH];
    logic [N-1:0]  test_mem [DEPTH];

    assign idle       = (state_q == StIdle);
    assign issue      = (state_q == StRun);
    assign issue_last = issue && (i_q == imax_q) && (j_q == jmax_q);
    // A start in IDLE is always accepted, so any coincident write is dropped.
    assign wr_ok      = wr_en && idle && !start;

    // FSM and pair counters: i sweeps the template inside each test index j.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        imax_d  = imax_q;
        jmax_d  = jmax_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    if (tmpl_len == '0 || test_len == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d = StRun;
                        i_d     = '0;
                        j_d     = '0;
                        imax_d  = last_index(tmpl_len);
                        jmax_d  = last_index(test_len);
                    end
                end
            end
            StRun: begin
                if (i_q == imax_q) begin
                    i_d = '0;
                    if (j_q == jmax_q) begin
                        state_d = StDrain;
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            StDrain: begin
                if (!tag_busy) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            i_q     <= '0;
            j_q     <= '0;
            imax_q  <= '0;
            jmax_q  <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            imax_q  <= imax_d;
            jmax_q  <= jmax_d;
        end
    end

    // Sequence buffers: synchronous write and read, contents not reset.
    always_ff @(posedge clk) begin
        if (wr_ok && !wr_sel) begin
            tmpl_mem[wr_addr] <= wr_data;
        end
        if (wr_ok && wr_sel) begin
            test_mem[wr_addr] <= wr_data;
        end
        if (issue) begin
            tmpl_rd_q <= tmpl_mem[i_q];
            test_rd_q <= test_mem[j_q];
        end
    end

    // Output stage to the distance unit; holds the last pair outside RUN.
    always_comb begin
        rd_vld_d        = issue;
        template_data_d = rd_vld_q ? tmpl_rd_q : template_data_q;
        test_data_d     = rd_vld_q ? test_rd_q : test_data_q;
    end

    dtw_tag_delay #(
        .STAGES (LAT + 2),
        .AW     (AW)
    ) u_tag_delay (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (issue),
        .in_i      (i_q),
        .in_j      (j_q),
        .in_last   (issue_last),
        .out_valid (tag_valid),
        .out_i     (tag_i),
        .out_j     (tag_j),
        .out_last  (tag_last),
        .any_valid (tag_busy)
    );

    // Capture the returned distance with its aligned tag; hold when no tag.
    always_comb begin
        dist_valid_d = tag_valid;
        dist_last_d  = tag_valid && tag_last;
        dist_i_d     = tag_valid ? tag_i : dist_i_q;
        dist_j_d     = tag_valid ? tag_j : dist_j_q;
        dist_data_d  = tag_valid ? euclid_in : dist_data_q;
    end

    // Datapath output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_q        <= 1'b0;
            template_data_q <= '0;
            test_data_q     <= '0;
            dist_valid_q    <= 1'b0;
            dist_last_q     <= 1'b0;
            dist_i_q        <= '0;
            dist_j_q        <= '0;
            dist_data_q     <= '0;
        end else begin
            rd_vld_q        <= rd_vld_d;
            template_data_q <= template_data_d;
            test_data_q     <= test_data_d;
            dist_valid_q    <= dist_valid_d;
            dist_last_q     <= dist_last_d;
            dist_i_q        <= dist_i_d;
            dist_j_q        <= dist_j_d;
            dist_data_q     <= dist_data_d;
        end
    end

    assign busy          = !idle;
    assign done          = (state_q == StDone);
    assign template_data = template_data_q;
    assign test_data     = test_data_q;
    assign dist_valid    = dist_valid_q;
    assign dist_last     = dist_last_q;
    assign dist_i        = dist_i_q;
    assign dist_j        = dist_j_q;
    assign dist_data     = dist_data_q;

endmodule

// File: tb/tb_dtw_pair_feeder.sv
// Randomised self-checking bench for dtw_pair_feeder with a behavioural
// distance unit and an expected-beat queue built from the sequence contents.
module tb_dtw_pair_feeder;

    localparam int N     = 32;
    localparam int M     = 16;
    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int LAT   = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic          wr_sel = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [N-1:0]  wr_data = '0;
    logic [AW:0]   tmpl_len = '0;
    logic [AW:0]   test_len = '0;
    logic          start = 1'b0;
    logic          busy, done, dist_valid, dist_last;
    logic [N-1:0]  template_data, test_data;
    logic [M-1:0]  euclid_in, dist_data;
    logic [AW-1:0] dist_i, dist_j;

    dtw_pair_feeder #(
        .N     (N),
        .M     (M),
        .DEPTH (DEPTH),
        .AW    (AW),
        .LAT   (LAT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_en         (wr_en),
        .wr_sel        (wr_sel),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .tmpl_len      (tmpl_len),
        .test_len      (test_len),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .template_data (template_data),
        .test_data     (test_data),
        .euclid_in     (euclid_in),
        .dist_valid    (dist_valid),
        .dist_i        (dist_i),
        .dist_j        (dist_j),
        .dist_data     (dist_data),
        .dist_last     (dist_last)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // floor(sqrt(sum of squared signed byte differences))
    function automatic int dist_f(input logic [31:0] a, input logic [31:0] b);
        int s;
        int r;
        int d;
        s = 0;
        r = 0;
        for (int k = 0; k < 4; k++) begin
            d = int'($signed(a[8*k +: 8])) - int'($signed(b[8*k +: 8]));
            s += d * d;
        end
        while ((r + 1) * (r + 1) <= s) r++;
        return r;
    endfunction

    // Distance unit: LAT cycles from template/test data to euclid_in.
    logic [M-1:0] du_q [LAT];
    always @(posedge clk) begin
        du_q[0] <= M'(dist_f(template_data, test_data));
        for (int k = 1; k < LAT; k++) du_q[k] <= du_q[k-1];
    end
    assign euclid_in = du_q[LAT-1];

    typedef struct packed {
        logic [AW-1:0] i;
        logic [AW-1:0] j;
        logic [M-1:0]  d;
        logic          last;
    } beat_t;

    beat_t       exp_q [$];
    beat_t       mon_e;
    logic [31:0] tm [DEPTH];
    logic [31:0] ts [DEPTH];

    int beats, first_cyc, last_cyc, done_cyc, done_cnt, busy_cnt, start_cyc;

    // Output monitor: every beat must be the next expected pair.
    always @(negedge clk) begin
        if (dist_valid) begin
            if (exp_q.size() == 0) begin
                check("extra_beat", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("dist_i", dist_i, mon_e.i);
                check("dist_j", dist_j, mon_e.j);
                check("dist_data", dist_data, mon_e.d);
                check("dist_last", dist_last, mon_e.last);
            end
            if (beats == 0) first_cyc = cyc;
            last_cyc = cyc;
            beats++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy) busy_cnt++;
    end

    task automatic wr(input logic sel, input int addr, input logic [31:0] data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = AW'(addr);
        wr_data = data;
        if (sel) ts[addr] = data;
        else     tm[addr] = data;
        @(posedge clk);
        #1 wr_en = 1'b0;
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_done"}, done, 0);
        check({pfx, "_tmpl"}, template_data, 0);
        check({pfx, "_test"}, test_data, 0);
        check({pfx, "_valid"}, dist_valid, 0);
        check({pfx, "_i"}, dist_i, 0);
        check({pfx, "_j"}, dist_j, 0);
        check({pfx, "_data"}, dist_data, 0);
        check({pfx, "_last"}, dist_last, 0);
    endtask

    task automatic build_exp(input int rows, input int cols);
        beat_t b;
        exp_q.delete();
        for (int j = 0; j < cols; j++) begin
            for (int i = 0; i < rows; i++) begin
                b.i    = AW'(i);
                b.j    = AW'(j);
                b.d    = M'(dist_f(tm[i], ts[j]));
                b.last = (i == rows - 1) && (j == cols - 1);
                exp_q.push_back(b);
            end
        end
        beats = 0; done_cnt = 0; busy_cnt = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1;
    endtask

    // One run; disturb pokes start and writes while the run is in progress.
    task automatic run(input int tl, input int tel, input bit disturb);
        int rows, cols, rc, guard;
        rows = (tl > DEPTH) ? DEPTH : tl;
        cols = (tel > DEPTH) ? DEPTH : tel;
        rc   = rows * cols;
        build_exp(rows, cols);
        @(posedge clk);
        #1;
        tmpl_len = (AW+1)'(tl);
        test_len = (AW+1)'(tel);
        start    = 1'b1;
        if (disturb) begin
            wr_en = 1'b1; wr_sel = 1'b0; wr_addr = '0; wr_data = ~tm[0];
        end
        @(posedge clk);
        #1;
        start_cyc = cyc;
        start = 1'b0;
        wr_en = 1'b0;
        guard = 0;
        while (done_cnt == 0 && guard < rc + 50) begin
            @(posedge clk);
            #1;
            guard++;
            if (disturb && (guard == 3 || guard == 4)) begin
                start   = 1'b1;
                wr_en   = 1'b1;
                wr_sel  = (guard == 3);
                wr_addr = AW'(guard - 2);
                wr_data = ~wr_data;
            end else begin
                start = 1'b0;
                wr_en = 1'b0;
            end
        end
        repeat (4) @(negedge clk);
        check("done_seen", done_cnt, 1);
        check("beats", beats, rc);
        check("queue_empty", exp_q.size(), 0);
        if (rc > 0) begin
            check("first_lat", first_cyc - start_cyc, LAT + 3);
            check("no_gaps", last_cyc - first_cyc + 1, beats);
            check("done_after_last", done_cyc, last_cyc + 1);
            check("busy_cycles", busy_cnt, rc + LAT + 4);
            check("hold_tmpl", template_data, tm[rows-1]);
            check("hold_test", test_data, ts[cols-1]);
            check("hold_data", dist_data, dist_f(tm[rows-1], ts[cols-1]));
        end else begin
            check("empty_done_lat", done_cyc - start_cyc, 0);
            check("empty_busy", busy_cnt, 1);
        end
    endtask

    // Reset in the middle of a run; afterwards nothing may come out.
    task automatic abort_run(input int tl, input int tel);
        int guard;
        build_exp(tl, tel);
        @(posedge clk);
        #1;
        tmpl_len = (AW+1)'(tl);
        test_len = (AW+1)'(tel);
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        guard = 0;
        while (beats < 5 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        #1;
        check("abort_reached", beats >= 5, 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        check("abort_no_done", done_cnt, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        // T1: known distances 5 and 0
        wr(1'b0, 0, 32'h0304_0000);
        wr(1'b0, 1, 32'h0000_0000);
        wr(1'b1, 0, 32'h0000_0000);
        run(2, 1, 1'b0);

        // T2: random 4x3
        for (int k = 0; k < 4; k++) wr(1'b0, k, $urandom);
        for (int k = 0; k < 3; k++) wr(1'b1, k, $urandom);
        run(4, 3, 1'b0);

        // T3: empty runs
        run(0, 3, 1'b0);
        run(4, 0, 1'b0);

        // T4: start and writes while busy are ignored, buffers intact
        run(4, 3, 1'b1);
        run(4, 3, 1'b0);

        // T5: abort then full restart
        abort_run(4, 3);
        run(4, 3, 1'b0);

        // T6: full size and clamping
        for (int k = 0; k < DEPTH; k++) wr(1'b0, k, $urandom);
        for (int k = 0; k < DEPTH; k++) wr(1'b1, k, $urandom);
        run(64, 64, 1'b0);
        run(65, 2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
